// File: rtl/result_drain_pkg.sv
// result_drain_pkg: shared FSM encoding and result word geometry for the result drain
package result_drain_pkg;
  localparam int RESULT_WIDTH = 64;
  localparam int BEAT_WIDTH = 16;
  localparam int BEATS = RESULT_WIDTH / BEAT_WIDTH;
  typedef enum logic [1:0] {IDLE = 2'b00, POP = 2'b01, LOAD = 2'b10, SEND = 2'b11} state_t;
endpackage

// File: rtl/result_drain.sv
// result_drain: pops result words from the output FIFO and streams them out LSB-chunk first as valid/ready beats
// ports: clk, rst (async, active-low); drain_en, empty_outputfifo, RD_EN_outputfifo, q_outputfifo (FIFO side);
//        tx_data, tx_valid, tx_last, tx_ready (off-chip beat port); busy, word_cnt (status)
module result_drain
  import result_drain_pkg::*;
#(
  parameter int FIFO_WIDTH = RESULT_WIDTH,
  parameter int OUT_WIDTH = BEAT_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  drain_en,
  input  logic                  empty_outputfifo,
  output logic                  RD_EN_outputfifo,
  input  logic [FIFO_WIDTH-1:0] q_outputfifo,
  output logic [OUT_WIDTH-1:0]  tx_data,
  output logic                  tx_valid,
  output logic                  tx_last,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_cnt
);
  localparam int NB = FIFO_WIDTH / OUT_WIDTH;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam logic [BW-1:0] LAST = BW'(NB - 1);
  state_t state, state_nxt;
  logic [FIFO_WIDTH-1:0] shreg;
  logic [BW-1:0] beat_cnt;
  logic fire;
  // the pop strobe is gated by rst so it drops the instant reset asserts, not at the next edge
  always_comb begin
    tx_valid = state == SEND;
    tx_last = tx_valid && beat_cnt == LAST;
    tx_data = shreg[OUT_WIDTH-1:0];
    busy = state != IDLE;
    fire = tx_valid && tx_ready;
    RD_EN_outputfifo = rst && state == IDLE && drain_en && !empty_outputfifo;
    state_nxt = state == IDLE ? (RD_EN_outputfifo ? POP : IDLE) :
                state == POP  ? LOAD :
                state == LOAD ? SEND :
                (fire && tx_last) ? IDLE : SEND;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      shreg <= '0;
      beat_cnt <= '0;
      word_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == LOAD) begin
        shreg <= q_outputfifo;
        beat_cnt <= '0;
      end else if (fire) begin
        shreg <= shreg >> OUT_WIDTH;
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (fire && tx_last) word_cnt <= word_cnt + 1'b1;
    end
endmodule

// File: tb/tb_result_drain.sv
// tb_result_drain: directed table and sequence checks for result_drain
module tb_result_drain;
  logic clk = 0, rst, drain_en, empty, rd_en, tx_valid, tx_last, tx_ready, busy;
  logic [63:0] q;
  logic [15:0] tx_data, word_cnt;
  logic rd_en2, tx_valid2, tx_last2, busy2;
  logic [15:0] tx_data2;
  logic [1:0] wc2;
  result_drain dut (.clk(clk), .rst(rst), .drain_en(drain_en), .empty_outputfifo(empty),
    .RD_EN_outputfifo(rd_en), .q_outputfifo(q), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_last(tx_last), .tx_ready(tx_ready), .busy(busy), .word_cnt(word_cnt));
  result_drain #(.CNT_WIDTH(2)) dut2 (.clk(clk), .rst(rst), .drain_en(drain_en), .empty_outputfifo(empty),
    .RD_EN_outputfifo(rd_en2), .q_outputfifo(q), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_last(tx_last2), .tx_ready(tx_ready), .busy(busy2), .word_cnt(wc2));
  always #5 clk = ~clk;
  logic [63:0] mem [16];
  logic [3:0] wr_ptr = 0, rd_ptr = 0;
  assign empty = wr_ptr == rd_ptr;
  always @(posedge clk) if (rd_en) begin
    q <= mem[rd_ptr];
    rd_ptr <= rd_ptr + 1'b1;
  end
  int cyc = 0, nb = 0, rd_cnt = 0, underflow = 0, send_cyc = 0, stall_err = 0, first_valid = 0, twin_err = 0;
  int rd_time [32];
  logic [15:0] beats [128];
  logic lasts [128];
  logic prev_valid = 0, prev_ready = 0, prev_last = 0;
  logic [15:0] prev_data = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (rd_en) begin
      if (empty) underflow++;
      rd_time[rd_cnt] = cyc;
      rd_cnt++;
    end
    if (tx_valid && !prev_valid) first_valid = cyc;
    if (tx_valid) send_cyc++;
    if (prev_valid && !prev_ready && (tx_valid !== 1'b1 || tx_data !== prev_data || tx_last !== prev_last)) stall_err++;
    if (tx_valid && tx_ready) begin
      beats[nb] = tx_data;
      lasts[nb] = tx_last;
      nb++;
    end
    if ({rd_en2, tx_valid2, tx_last2, busy2, tx_data2} !== {rd_en, tx_valid, tx_last, busy, tx_data}) twin_err++;
    prev_valid = tx_valid;
    prev_ready = tx_ready;
    prev_data = tx_data;
    prev_last = tx_last;
  end
  int n_pass = 0, n_total = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [63:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1'b1;
  endtask
  task automatic wait_beats(input int target, input int budget, input string name);
    for (int k = 0; k < budget && nb < target; k++) tick;
    chk(name, 64'(nb >= target), 64'd1);
  endtask
  typedef struct {
    logic [63:0] w;
    logic [3:0][15:0] b;
  } vec_t;
  vec_t vec [3];
  logic [63:0] lw [5];
  int nb0, rd0, sc0, st0, uf0, exp_words;
  initial begin
    vec[0] = '{64'h1122_3344_5566_7788, {16'h1122, 16'h3344, 16'h5566, 16'h7788}};
    vec[1] = '{64'hFFFF_0000_A5A5_0001, {16'hFFFF, 16'h0000, 16'hA5A5, 16'h0001}};
    vec[2] = '{64'h0123_4567_89AB_CDEF, {16'h0123, 16'h4567, 16'h89AB, 16'hCDEF}};
    exp_words = 0;
    rst = 0;
    drain_en = 1;
    tx_ready = 0;
    repeat (3) tick;
    chk("reset_outputs", {rd_en, tx_valid, tx_last, busy, tx_data, word_cnt}, 64'd0);
    rst = 1;
    repeat (5) tick;
    chk("idle_no_pop", 64'(rd_cnt), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    tx_ready = 1;
    for (int i = 0; i < 3; i++) begin
      nb0 = nb;
      rd0 = rd_cnt;
      push(vec[i].w);
      wait_beats(nb0 + 4, 20, $sformatf("tbl%0d_timeout", i));
      repeat (2) tick;
      exp_words++;
      for (int k = 0; k < 4; k++)
        chk($sformatf("tbl%0d_beat%0d", i, k), {47'd0, lasts[nb0+k], beats[nb0+k]}, {47'd0, k == 3, vec[i].b[k]});
      chk($sformatf("tbl%0d_pops", i), 64'(rd_cnt - rd0), 64'd1);
      chk($sformatf("tbl%0d_word_cnt", i), 64'(word_cnt), 64'(exp_words));
      chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'd0);
      if (i == 0) chk("pop_to_valid_latency", 64'(first_valid - rd_time[rd0]), 64'd3);
    end
    nb0 = nb;
    sc0 = send_cyc;
    st0 = stall_err;
    push(64'h1122_3344_5566_7788);
    for (int k = 0; k < 40 && nb < nb0 + 4; k++) begin
      tick;
      tx_ready = tx_valid ? ~tx_ready : 1'b1;
    end
    repeat (2) tick;
    exp_words++;
    for (int k = 0; k < 4; k++)
      chk($sformatf("bp_beat%0d", k), {47'd0, lasts[nb0+k], beats[nb0+k]}, {47'd0, k == 3, vec[0].b[k]});
    chk("bp_send_cycles", 64'(send_cyc - sc0), 64'd8);
    chk("bp_stable", 64'(stall_err - st0), 64'd0);
    chk("bp_word_cnt", 64'(word_cnt), 64'(exp_words));
    tx_ready = 1;
    nb0 = nb;
    rd0 = rd_cnt;
    uf0 = underflow;
    push(64'h0004_0003_0002_0001);
    push(64'h0008_0007_0006_0005);
    push(64'h000C_000B_000A_0009);
    wait_beats(nb0 + 12, 40, "b2b_timeout");
    repeat (2) tick;
    exp_words += 3;
    for (int k = 0; k < 12; k++)
      chk($sformatf("b2b_beat%0d", k), {47'd0, lasts[nb0+k], beats[nb0+k]}, {47'd0, k % 4 == 3, 16'(k + 1)});
    chk("b2b_pops", 64'(rd_cnt - rd0), 64'd3);
    chk("b2b_gap01", 64'(rd_time[rd0+1] - rd_time[rd0]), 64'd7);
    chk("b2b_gap12", 64'(rd_time[rd0+2] - rd_time[rd0+1]), 64'd7);
    chk("b2b_underflow", 64'(underflow - uf0), 64'd0);
    chk("b2b_word_cnt", 64'(word_cnt), 64'(exp_words));
    lw[0] = 64'hDEAD_BEEF_CAFE_F00D;
    lw[1] = 64'h0BAD_F00D_1234_5678;
    nb0 = nb;
    rd0 = rd_cnt;
    push(lw[0]);
    push(lw[1]);
    for (int k = 0; k < 20 && nb < nb0 + 2; k++) tick;
    drain_en = 0;
    repeat (15) tick;
    chk("drain_off_beats", 64'(nb - nb0), 64'd4);
    chk("drain_off_pops", 64'(rd_cnt - rd0), 64'd1);
    chk("drain_off_busy", 64'(busy), 64'd0);
    drain_en = 1;
    wait_beats(nb0 + 8, 20, "drain_resume_timeout");
    repeat (2) tick;
    exp_words += 2;
    chk("drain_resume_pops", 64'(rd_cnt - rd0), 64'd2);
    for (int k = 0; k < 8; k++)
      chk($sformatf("drain_beat%0d", k), {47'd0, lasts[nb0+k], beats[nb0+k]}, {47'd0, k % 4 == 3, lw[k/4][16*(k%4) +: 16]});
    lw[0] = 64'h4444_3333_2222_1111;
    lw[1] = 64'h8888_7777_6666_5555;
    nb0 = nb;
    push(lw[0]);
    push(lw[1]);
    for (int k = 0; k < 20 && nb < nb0 + 2; k++) tick;
    #2 rst = 0;
    #1 chk("async_reset_outputs", {rd_en, tx_valid, tx_last, busy, tx_data, word_cnt}, 64'd0);
    chk("async_reset_cnt2", 64'(wc2), 64'd0);
    exp_words = 0;
    repeat (2) tick;
    rst = 1;
    wait_beats(nb0 + 6, 20, "post_reset_timeout");
    repeat (2) tick;
    exp_words = 1;
    for (int k = 0; k < 4; k++)
      chk($sformatf("post_reset_beat%0d", k), {47'd0, lasts[nb0+2+k], beats[nb0+2+k]}, {47'd0, k == 3, lw[1][16*k +: 16]});
    chk("post_reset_word_cnt", 64'(word_cnt), 64'(exp_words));
    rst = 0;
    tick;
    rst = 1;
    nb0 = nb;
    for (int k = 0; k < 5; k++) push({16'(4*k+4), 16'(4*k+3), 16'(4*k+2), 16'(4*k+1)});
    for (int k = 0; k < 60 && nb < nb0 + 16; k++) tick;
    chk("wrap_cnt2_at4", 64'(wc2), 64'd0);
    chk("wrap_cnt16_at4", 64'(word_cnt), 64'd4);
    wait_beats(nb0 + 20, 20, "wrap_timeout");
    repeat (2) tick;
    chk("wrap_cnt2_at5", 64'(wc2), 64'd1);
    chk("wrap_cnt16_at5", 64'(word_cnt), 64'd5);
    for (int k = 0; k < 20; k++)
      chk($sformatf("wrap_beat%0d", k), {47'd0, lasts[nb0+k], beats[nb0+k]}, {47'd0, k % 4 == 3, 16'(k + 1)});
    chk("narrow_counter_twin", 64'(twin_err), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/result_drain.md
Name: result_drain

Overview:
- Consumer side of the result FIFO. Pops 64-bit result words written by the CIM controller and serialises each into OUT_WIDTH-bit beats on an off-chip valid/ready port.
- Sits between the output FIFO read port and the chip pad/host link.
- Keeps a running count of words drained for host status readback.

Parameters:
- FIFO_WIDTH, 64, width of the result word read from the output FIFO.
- OUT_WIDTH, 16, width of one off-chip beat; must divide FIFO_WIDTH exactly.
- CNT_WIDTH, 16, width of the drained-word counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- drain_en  input  1  level; 1 allows new words to be popped.
- empty_outputfifo  input  1  output FIFO empty flag.
- RD_EN_outputfifo  output  1  single-cycle pop strobe to the output FIFO.
- q_outputfifo  input  FIFO_WIDTH  FIFO read data; valid the cycle after RD_EN_outputfifo.
- tx_data  output  OUT_WIDTH  current beat.
- tx_valid  output  1  beat valid.
- tx_last  output  1  marks the final beat of a word.
- tx_ready  input  1  sink accepts the beat when tx_valid & tx_ready.
- busy  output  1  high in any state other than IDLE.
- word_cnt  output  CNT_WIDTH  number of words fully transmitted; wraps.

Behaviour:
- Reset (rst=0, asynchronous, takes effect mid-operation too):
  - state=IDLE; RD_EN_outputfifo=0, tx_valid=0, tx_last=0, tx_data=0, busy=0, word_cnt=0.
  - Shift register and beat counter cleared.
  - Any partially sent word is discarded.
- BEATS = FIFO_WIDTH/OUT_WIDTH (4 at defaults). Beat counter width = clog2(BEATS), minimum 1.
- States:
  - IDLE: if drain_en & !empty_outputfifo, assert RD_EN_outputfifo for exactly one cycle and go to POP; otherwise stay.
  - POP: RD_EN_outputfifo=0. Wait one cycle for FIFO read latency, then go to LOAD.
  - LOAD: capture q_outputfifo into shift register; beat_cnt=0; go to SEND.
  - SEND:
    - Outputs: tx_valid=1; tx_data = shreg[OUT_WIDTH-1:0] (least-significant chunk first); tx_last = (beat_cnt==BEATS-1).
    - On tx_ready: shift shreg right by OUT_WIDTH and increment beat_cnt.
    - On tx_ready with tx_last: word_cnt+1 (wraps at 2^CNT_WIDTH), go to IDLE.
    - Without tx_ready: hold tx_data/tx_valid/tx_last stable (AXI-style; valid is never withdrawn).
- Pop-to-first-beat latency: RD_EN at cycle t, tx_valid rises at cycle t+3.
- Minimum word period with tx_ready tied high: 3 + BEATS cycles (7 at defaults).
- drain_en=0 mid-word: the current word completes; no new pop.
- empty_outputfifo is sampled only in IDLE. It goes high after the pop with no effect.
- No pop is ever issued while busy. This guarantees at most one word outstanding, so no FIFO underflow.
- tx_ready high outside SEND is ignored.
- If reset is released while tx_ready=1, the first beat is still produced only via the normal IDLE→POP→LOAD→SEND path.

Decomposition:
- Shared package:
  - state encoding: IDLE=2'b00, POP=2'b01, LOAD=2'b10, SEND=2'b11;
  - localparam BEATS;
  - result word width constant (64), shared with the controller.
- No sub-module required. FSM, shift register and counters are kept in one module.

Test Plan:
- Reset then idle: rst low for 3 cycles, FIFO empty, drain_en=1 → all outputs 0, RD_EN never asserted, busy=0.
- Single word, tx_ready=1:
  - FIFO holds 64'h1122_3344_5566_7788 → beats 16'h7788, 16'h5566, 16'h3344, 16'h1122.
  - tx_last only on 16'h1122.
  - Exactly one RD_EN pulse; word_cnt=1.
  - First tx_valid 3 cycles after RD_EN.
- Backpressure: tx_ready toggles 0/1 every cycle during the same word → tx_data stable while ready=0, no beat duplicated or skipped, 8 cycles in SEND.
- Back-to-back: 3 words queued, tx_ready=1 → 3 RD_EN pulses 7 cycles apart, 12 beats in order, word_cnt=3, empty never underflowed.
- drain_en dropped after the second beat of a word → remaining 2 beats still sent, no further RD_EN while drain_en=0, resumes when drain_en=1.
- Async reset mid-SEND after beat 2 → outputs 0 immediately (before next clk edge), word_cnt=0; after release, the next queued word is sent from its first beat.
- word_cnt wrap: preload by sending 65536 words with CNT_WIDTH=16 (or override CNT_WIDTH=2 and send 5) → count wraps to 0 then 1.
